// File: rtl/comp_msd_seq.sv
// Multi-cycle wide comparator: scans one limb per cycle, most-significant limb first.
// Optional build macro COMP_SIGNED_EN selects two's-complement compare (default: unsigned).
module comp_msd_seq #(
    parameter int DATA_W = 1024,
    parameter int LIMB_W = 64,
    parameter int IDX_W  = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_gt,
    output logic              out_lt,
    output logic              out_eq,
    output logic [IDX_W-1:0]  out_idx
);

    localparam int NL    = DATA_W / LIMB_W;
    localparam int CNT_W = (NL > 1) ? $clog2(NL) : 1;
    localparam logic [CNT_W-1:0] TOP = CNT_W'(NL - 1);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // in_ready is high only in IDLE, out_valid only in DONE, and DONE holds until out_ready.
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t             state, state_nx;
    logic               load, dec, finish;
    logic [DATA_W-1:0]  a_q, b_q;
    logic [CNT_W-1:0]   cnt;
    logic [LIMB_W-1:0]  a_limb, b_limb, a_cmp, b_cmp, diff_x;
    logic               limb_diff;
    logic [IDX_W-1:0]   hi_pos, idx_calc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        dec      = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    load     = 1'b1;
                    state_nx = SCAN;
                end
            end
            SCAN: begin
                if (limb_diff || cnt == '0) begin
                    finish   = 1'b1;
                    state_nx = DONE;
                end else begin
                    dec = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Only one LIMB_W slice feeds the magnitude compare and priority encoder.
    always_comb begin
        a_limb = a_q[int'(cnt)*LIMB_W +: LIMB_W];
        b_limb = b_q[int'(cnt)*LIMB_W +: LIMB_W];
`ifdef COMP_SIGNED_EN
        // Flipping both sign bits on the top limb turns signed order into unsigned order.
        a_cmp = a_limb ^ ((cnt == TOP) ? (LIMB_W'(1) << (LIMB_W - 1)) : '0);
        b_cmp = b_limb ^ ((cnt == TOP) ? (LIMB_W'(1) << (LIMB_W - 1)) : '0);
`else
        a_cmp = a_limb;
        b_cmp = b_limb;
`endif
        diff_x    = a_limb ^ b_limb;
        limb_diff = |diff_x;
        hi_pos    = '0;
        for (int i = 0; i < LIMB_W; i++) begin
            if (diff_x[i]) hi_pos = IDX_W'(i);
        end
        idx_calc = IDX_W'(cnt) * IDX_W'(LIMB_W) + hi_pos;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            cnt     <= '0;
            out_gt  <= 1'b0;
            out_lt  <= 1'b0;
            out_eq  <= 1'b0;
            out_idx <= '0;
        end else begin
            if (load) begin
                a_q <= in_a;
                b_q <= in_b;
                cnt <= TOP;
            end else if (dec) begin
                cnt <= cnt - 1'b1;
            end
            if (finish) begin
                out_gt  <= limb_diff && (a_cmp > b_cmp);
                out_lt  <= limb_diff && !(a_cmp > b_cmp);
                out_eq  <= !limb_diff;
                out_idx <= limb_diff ? idx_calc : '0;
            end
        end
    end

endmodule

// File: tb/tb_comp_msd_seq.sv
// Self-checking bench for comp_msd_seq: directed table, hand-written corner sequences,
// and randomized operands checked against a full-width arithmetic reference model.
module tb_comp_msd_seq;

    localparam int DATA_W = 1024;
    localparam int LIMB_W = 64;
    localparam int IDX_W  = $clog2(DATA_W);
    localparam int NL     = DATA_W / LIMB_W;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              out_valid;
    logic              out_ready;
    logic              out_gt;
    logic              out_lt;
    logic              out_eq;
    logic [IDX_W-1:0]  out_idx;

    int vectors;
    int miscompares;

    comp_msd_seq #(.DATA_W(DATA_W), .LIMB_W(LIMB_W), .IDX_W(IDX_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_gt   (out_gt),
        .out_lt   (out_lt),
        .out_eq   (out_eq),
        .out_idx  (out_idx)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              gt;
        logic              lt;
        logic              eq;
        logic [IDX_W-1:0]  idx;
        int                lat;
        int                hold;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_wide();
        logic [DATA_W-1:0] v;
        for (int w = 0; w < DATA_W / 32; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference: whole-operand arithmetic, then latency from which limb holds the top difference.
    task automatic model(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                         output logic gt, output logic lt, output logic eq,
                         output logic [IDX_W-1:0] idx, output int lat);
        logic [DATA_W-1:0] x;
        x   = a ^ b;
        eq  = (a == b);
`ifdef COMP_SIGNED_EN
        gt  = $signed(a) > $signed(b);
        lt  = $signed(a) < $signed(b);
`else
        gt  = a > b;
        lt  = a < b;
`endif
        idx = '0;
        lat = NL;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (x[i]) begin
                idx = IDX_W'(i);
                lat = NL - i / LIMB_W;
                break;
            end
        end
    endtask

    // Driver: offer a pair in IDLE; returns at #1 after the accept edge.
    task automatic start_op(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        chk("in_ready_idle", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a     = rand_wide();
        in_b     = rand_wide();
    endtask

    task automatic run_op(input vec_t v);
        int lat;
        start_op(v.a, v.b);
        lat = 0;
        while (!out_valid && lat < NL + 4) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("out_valid_rise", out_valid, 1'b1);
        chk("latency", lat, v.lat);
        chk("out_gt", out_gt, v.gt);
        chk("out_lt", out_lt, v.lt);
        chk("out_eq", out_eq, v.eq);
        chk("out_idx", out_idx, v.idx);
        // Backpressure: DONE must hold while in_valid/in_a wiggle.
        for (int h = 0; h < v.hold; h++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_a     = rand_wide();
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_in_ready", in_ready, 1'b0);
            chk("hold_result", {out_gt, out_lt, out_eq, out_idx}, {v.gt, v.lt, v.eq, v.idx});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_valid", out_valid, 1'b0);
        chk("release_in_ready", in_ready, 1'b1);
    endtask

    vec_t tbl[5];
    vec_t rv;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b1;
        in_a        = '1;
        in_b        = '0;
        out_ready   = 1'b0;

        // Test plan scenarios 1-5 as table entries
        tbl[0] = '{a: '0, b: '0, gt: 0, lt: 0, eq: 1, idx: 0, lat: 16, hold: 0};
        tbl[1] = '{a: 5, b: 7, gt: 0, lt: 1, eq: 0, idx: 1, lat: 16, hold: 5};
        tbl[2] = '{a: '0, b: '0, gt: 1, lt: 0, eq: 0, idx: 1023, lat: 1, hold: 1};
        tbl[2].a[DATA_W-1] = 1'b1;
`ifdef COMP_SIGNED_EN
        tbl[2].gt = 1'b0;
        tbl[2].lt = 1'b1;
`endif
        tbl[3] = '{a: '0, b: '0, gt: 1, lt: 0, eq: 0, idx: 700, lat: 6, hold: 2};
        tbl[3].a[700] = 1'b1;
        tbl[3].b[699] = 1'b1;
        tbl[3].b[1:0] = 2'b11;
        tbl[4] = '{a: 1, b: 0, gt: 1, lt: 0, eq: 0, idx: 0, lat: 16, hold: 0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_flags", {out_gt, out_lt, out_eq}, 3'b000);
        chk("rst_idx", out_idx, '0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", in_ready, 1'b1);

        for (int i = 0; i < 5; i++) run_op(tbl[i]);

        // Reset pulse mid-SCAN drops the pending result.
        start_op('0, '0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < NL + 4; c++) begin
                @(posedge clk); #1;
                if (out_valid) seen++;
            end
            chk("abort_no_valid", seen, 0);
        end
        chk("abort_in_ready_after", in_ready, 1'b1);
        run_op(tbl[4]);

        // Randomized operands against the reference model
        for (int n = 0; n < 60; n++) begin
            int mode;
            int k;
            mode = $urandom_range(0, 3);
            rv.a = rand_wide();
            rv.b = rv.a;
            case (mode)
                0: ;
                1: begin
                    k = $urandom_range(0, NL - 1);
                    rv.b[k*LIMB_W +: LIMB_W] = {32'($urandom), 32'($urandom)};
                end
                2: begin
                    k = $urandom_range(0, DATA_W - 1);
                    rv.b[k] = ~rv.b[k];
                end
                default: rv.b = rand_wide();
            endcase
            model(rv.a, rv.b, rv.gt, rv.lt, rv.eq, rv.idx, rv.lat);
            rv.hold = $urandom_range(0, 3);
            run_op(rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
